vga_timing_gen: RTL
===================

# vga_timing_gen

Generates VGA 640x480@60 raster timing from the system clock: pixel-rate strobe, horizontal/vertical counters, sync pulses, active-video flag and a once-per-frame refresh strobe. Its `pix_x`/`pix_y`/`refresh_tick` outputs feed the text and sprite renderers. Those renderers return a 12-bit colour, which this block registers and drives to the VGA DAC pins with blanking applied. It is the driving end of the pixel-coordinate interface that the renderers consume.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- `CLK_DIV`, 2, clk cycles per pixel (>=1)
- `ALIGN_DELAY`, 2, pixel ticks of sync/video_on delay when alignment is compiled in (>=1)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `rgb_in`  in  12  renderer colour {R[3:0],G[3:0],B[3:0]}
- `pixel_tick`  out  1  one-clk strobe per pixel period
- `pix_x`  out  10  horizontal count, 0..H_TOTAL-1
- `pix_y`  out  10  vertical count, 0..V_TOTAL-1
- `video_on`  out  1  pixel inside active area
- `refresh_tick`  out  1  one-clk strobe per frame
- `hsync`, `vsync`  out  1  sync pulses, active-low
- `vga_r`, `vga_g`, `vga_b`  out  4  DAC outputs

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be <=1024.
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pixel_tick` is registered high for exactly the clk in which div==CLK_DIV-1. With CLK_DIV=1 it is constantly high after reset.
- Counter update on each pixel_tick:
  - `pix_x` increments, wrapping H_TOTAL-1 -> 0.
  - On that x wrap, `pix_y` increments, wrapping V_TOTAL-1 -> 0.
  - Counters never change without pixel_tick.
- Sync and active-video decode:
  - `hsync` is low while pix_x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
  - `vsync` is low while pix_y is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
  - `video_on` = (pix_x<H_ACTIVE)&&(pix_y<V_ACTIVE).
  - Decode is from the next-count value and is registered on the same edge as the counters, so it is aligned with pix_x/pix_y.
- `refresh_tick` is high for one clk, on the pixel_tick that moves the counters to (x=0, y=V_ACTIVE). This marks the start of vertical blanking, once per frame.
- Colour: on each pixel_tick, {vga_r,vga_g,vga_b} <= video_on_out ? rgb_in : 0. Here video_on_out is the delayed flag when alignment is enabled (see Configuration) and `video_on` otherwise. DAC outputs hold their value between ticks.
- Blanking has priority: rgb_in is ignored outside the active area.

## Timing
- Reset (asynchronous, while reset==0): div=0, pix_x=0, pix_y=0, pixel_tick=0, refresh_tick=0, video_on=0, hsync=1, vsync=1, DAC outputs 0, delay line cleared to {hsync=1, vsync=1, video_on=0}.
- After reset deasserts, the first pixel_tick occurs on the CLK_DIV-th rising edge (the first edge when CLK_DIV=1).
- The first pixel_tick moves the counters to (1,0). video_on goes to 1 on that edge, since (0,0) is not flagged while in reset.
- Reset asserted mid-frame returns all state to reset values immediately, with no partial-line completion. Raster restarts at (0,0).
- Line period: H_TOTAL pixel ticks. Frame period: H_TOTAL*V_TOTAL pixel ticks (420000).
- Colour latency: rgb_in sampled at pixel_tick edge N appears on the DAC pins after edge N, one clk later.
- Simultaneous x-wrap and y-wrap: both counters go to 0 on the same edge. refresh_tick is not asserted on that edge.

## Configuration
- `VGA_SYNC_ALIGN_EN` defined:
  - hsync, vsync and the video_on used for DAC blanking pass through an ALIGN_DELAY-stage shift register, advanced on pixel_tick.
  - This compensates the renderer's registered coordinate decode plus the synchronous font ROM read.
  - The `video_on` output port itself stays undelayed.
- Not defined: hsync, vsync and blanking use the undelayed decode. No shift register is instantiated.

## Test plan
- Reset: hold reset=0 for 5 clks with rgb_in=12'hFFF -> all outputs at reset values. Release -> first pixel_tick on clk 2 (CLK_DIV=2), pix_x=1, pix_y=0.
- Line timing: run one line -> hsync low for exactly 96 pixel ticks, starting when pix_x reaches 656 (plus ALIGN_DELAY when the macro is defined). pix_x wraps 799->0 and pix_y increments.
- Frame timing: run 2 frames -> refresh_tick pulses once per 420000 pixel ticks, each pulse one clk wide, with pix_x=0, pix_y=480. vsync is low for 2 lines (1600 ticks).
- Blanking: rgb_in=12'hABC constant -> DAC = A/B/C exactly when video_on_out=1, and 0 during porches/sync.
- Alignment: with VGA_SYNC_ALIGN_EN and ALIGN_DELAY=2 -> hsync falls 2 pixel ticks after pix_x reaches 656. Without the macro, it falls on the same edge.
- Mid-frame reset: assert reset at pix_y=200, pix_x=300 -> counters 0 immediately. After release, raster restarts, and the first refresh_tick occurs 480*800 pixel ticks later.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (640x480@60 by default).
// Produces the pixel-rate strobe, pixel coordinates, sync pulses, the
// active-video flag and a once-per-frame refresh strobe. It also registers
// the renderer colour onto the DAC pins, with blanking applied.
// Optional compile-time macro: VGA_SYNC_ALIGN_EN. When it is defined,
// hsync, vsync and the DAC blanking flag are delayed by ALIGN_DELAY pixel
// ticks so they line up with the renderer pipeline.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_DIV     = 2,
    parameter int ALIGN_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rgb_in,
    output logic        pixel_tick,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        video_on,
    output logic        refresh_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // The 10-bit counters and the divider cannot represent other parameter sets
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (CLK_DIV < 1) || (ALIGN_DELAY < 1)) begin : g_bad_params
        $error("vga_timing_gen: illegal parameter set");
    end

    logic [DIV_W-1:0] div_r;
    logic             pixel_tick_r;
    logic [9:0]       x_r;
    logic [9:0]       y_r;
    logic             video_on_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             refresh_r;
    logic [11:0]      rgb_r;

    logic             tick_s;
    logic [9:0]       next_x_s;
    logic [9:0]       next_y_s;
    logic             hsync_next_s;
    logic             vsync_next_s;
    logic             video_next_s;
    logic             refresh_next_s;
    logic             hsync_out_s;
    logic             vsync_out_s;
    logic             video_out_s;

    // Next raster position and its decode; the decode is taken from the next
    // count so the registered flags line up with the registered counters
    always_comb begin
        tick_s   = (div_r == DIV_LAST);
        next_x_s = x_r;
        next_y_s = y_r;
        if (x_r == H_LAST) begin
            next_x_s = 10'd0;
            if (y_r == V_LAST) begin
                next_y_s = 10'd0;
            end else begin
                next_y_s = y_r + 10'd1;
            end
        end else begin
            next_x_s = x_r + 10'd1;
            next_y_s = y_r;
        end
        hsync_next_s   = !((next_x_s >= HS_FIRST) && (next_x_s <= HS_LAST));
        vsync_next_s   = !((next_y_s >= VS_FIRST) && (next_y_s <= VS_LAST));
        video_next_s   = (next_x_s < H_ACT) && (next_y_s < V_ACT);
        refresh_next_s = (next_x_s == 10'd0) && (next_y_s == V_ACT);
    end

    // Pixel-rate divider; the strobe rises on the edge the divider wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_r        <= {DIV_W{1'b0}};
            pixel_tick_r <= 1'b0;
        end else begin
            pixel_tick_r <= tick_s;
            if (tick_s) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    // Raster counters and undelayed sync / video / refresh flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_r        <= 10'd0;
            y_r        <= 10'd0;
            video_on_r <= 1'b0;
            hsync_r    <= 1'b1;
            vsync_r    <= 1'b1;
            refresh_r  <= 1'b0;
        end else if (tick_s) begin
            x_r        <= next_x_s;
            y_r        <= next_y_s;
            video_on_r <= video_next_s;
            hsync_r    <= hsync_next_s;
            vsync_r    <= vsync_next_s;
            refresh_r  <= refresh_next_s;
        end else begin
            refresh_r  <= 1'b0;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic [ALIGN_DELAY-1:0] hs_dly_r;
    logic [ALIGN_DELAY-1:0] vs_dly_r;
    logic [ALIGN_DELAY-1:0] vid_dly_r;

    // Delay sync and blanking to match the renderer's coordinate decode and font ROM read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_dly_r  <= {ALIGN_DELAY{1'b1}};
            vs_dly_r  <= {ALIGN_DELAY{1'b1}};
            vid_dly_r <= {ALIGN_DELAY{1'b0}};
        end else if (tick_s) begin
            for (int i = ALIGN_DELAY - 1; i > 0; i--) begin
                hs_dly_r[i]  <= hs_dly_r[i-1];
                vs_dly_r[i]  <= vs_dly_r[i-1];
                vid_dly_r[i] <= vid_dly_r[i-1];
            end
            hs_dly_r[0]  <= hsync_r;
            vs_dly_r[0]  <= vsync_r;
            vid_dly_r[0] <= video_on_r;
        end else begin
            hs_dly_r  <= hs_dly_r;
            vs_dly_r  <= vs_dly_r;
            vid_dly_r <= vid_dly_r;
        end
    end

    assign hsync_out_s = hs_dly_r[ALIGN_DELAY-1];
    assign vsync_out_s = vs_dly_r[ALIGN_DELAY-1];
    assign video_out_s = vid_dly_r[ALIGN_DELAY-1];
`else
    assign hsync_out_s = hsync_r;
    assign vsync_out_s = vsync_r;
    assign video_out_s = video_on_r;
`endif

    // DAC colour register: sample the renderer on each pixel, forced to black when blanked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_r <= 12'h000;
        end else if (tick_s) begin
            rgb_r <= video_out_s ? rgb_in : 12'h000;
        end else begin
            rgb_r <= rgb_r;
        end
    end

    assign pixel_tick   = pixel_tick_r;
    assign pix_x        = x_r;
    assign pix_y        = y_r;
    assign video_on     = video_on_r;
    assign refresh_tick = refresh_r;
    assign hsync        = hsync_out_s;
    assign vsync        = vsync_out_s;
    assign vga_r        = rgb_r[11:8];
    assign vga_g        = rgb_r[7:4];
    assign vga_b        = rgb_r[3:0];

endmodule
